// File: rtl/data_mem_responder.sv
// Byte-addressable little-endian data memory answering the core's memory stage.
// Word-crossing loads/stores take two cycles (IDLE -> SPLIT) and raise busy in the first.
module data_mem_responder #(
    parameter int WORD_LEN    = 32,
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 readEnable,
    input  logic                 writeEnable,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [2:0]           unitSize,
    input  logic [WORD_LEN-1:0]  writeData,
    output logic [WORD_LEN-1:0]  readData,
    output logic                 busy,
    output logic                 fault
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_SIZE:0] BYTE_LIMIT = (ADDR_SIZE+1)'(DEPTH_WORDS * 4);

    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state, stateNext;

    logic [WORD_LEN-1:0] mem [DEPTH_WORDS];
    logic [WORD_LEN-1:0] holdReg;

    logic [IDX_W-1:0]      wordIdx, nextIdx, wrIdx;
    logic [1:0]            offset;
    logic [2:0]            sizeBytes;
    logic [3:0]            sizeMask, wrLanes;
    logic                  illegalSize, crossing, outOfRange, active, reqFault;
    logic                  wrEn, latchHold;
    logic [ADDR_SIZE:0]    lastByte;
    logic [7:0]            laneAll;
    logic [2*WORD_LEN-1:0] dataAll;
    logic [WORD_LEN-1:0]   wordN, wordN1, loadRaw, wrData;

    function automatic logic [WORD_LEN-1:0] extendLoad(input logic [WORD_LEN-1:0] raw,
                                                       input logic [2:0] code);
        logic s;
        s = 1'b0;
        case (code[1:0])
            2'b00: begin
                s = ~code[2] & raw[7];
                return {{(WORD_LEN-8){s}}, raw[7:0]};
            end
            2'b01: begin
                s = ~code[2] & raw[15];
                return {{(WORD_LEN-16){s}}, raw[15:0]};
            end
            default: return raw;
        endcase
    endfunction

    assign wordIdx = addr[IDX_W+1:2];
    assign nextIdx = wordIdx + 1'b1;
    assign offset  = addr[1:0];

    always_comb begin
        sizeBytes = 3'd0;
        sizeMask  = 4'b0000;
        case (unitSize[1:0])
            2'b00:   begin sizeBytes = 3'd1; sizeMask = 4'b0001; end
            2'b01:   begin sizeBytes = 3'd2; sizeMask = 4'b0011; end
            2'b10:   begin sizeBytes = 3'd4; sizeMask = 4'b1111; end
            default: begin sizeBytes = 3'd0; sizeMask = 4'b0000; end
        endcase
    end

    assign illegalSize = (unitSize[1:0] == 2'b11) | (unitSize[2] & unitSize[1]);
    assign crossing    = ({2'b00, offset} + {1'b0, sizeBytes}) > 4'd4;
    assign lastByte    = {1'b0, addr} + (ADDR_SIZE+1)'(sizeBytes) - (ADDR_SIZE+1)'(1);
    assign outOfRange  = lastByte >= BYTE_LIMIT;
    assign active      = readEnable | writeEnable;
    assign reqFault    = active & (illegalSize | (readEnable & writeEnable) | outOfRange);

    // Lanes/data are laid out across a two-word window: low half is word N, high half word N+1.
    assign laneAll = {4'b0000, sizeMask} << offset;
    assign dataAll = {{WORD_LEN{1'b0}}, writeData} << {offset, 3'b000};
    assign wordN   = mem[wordIdx];
    assign wordN1  = mem[nextIdx];

    always_comb begin
        stateNext = IDLE;
        readData  = '0;
        busy      = 1'b0;
        fault     = 1'b0;
        wrEn      = 1'b0;
        wrIdx     = wordIdx;
        wrLanes   = 4'b0000;
        wrData    = dataAll[WORD_LEN-1:0];
        latchHold = 1'b0;
        loadRaw   = wordN >> {offset, 3'b000};
        if (rst) begin
            case (state)
                IDLE: begin
                    if (reqFault) begin
                        fault = 1'b1;
                    end else if (active) begin
                        if (crossing) begin
                            busy      = 1'b1;
                            stateNext = SPLIT;
                            latchHold = readEnable;
                        end else if (readEnable) begin
                            readData = extendLoad(loadRaw, unitSize);
                        end
                        if (writeEnable) begin
                            wrEn    = 1'b1;
                            wrLanes = laneAll[3:0];
                        end
                    end
                end
                SPLIT: begin
                    // Enables dropping here means the initiator abandoned the second half.
                    if (active) begin
                        loadRaw = holdReg | (wordN1 << (6'd32 - {1'b0, offset, 3'b000}));
                        if (readEnable) readData = extendLoad(loadRaw, unitSize);
                        if (writeEnable) begin
                            wrEn    = 1'b1;
                            wrIdx   = nextIdx;
                            wrLanes = laneAll[7:4];
                            wrData  = dataAll[2*WORD_LEN-1:WORD_LEN];
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            holdReg <= '0;
        end else begin
            state <= stateNext;
            if (latchHold) holdReg <= loadRaw;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (wrLanes[b]) mem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a byte-array memory model predicts every
// output cycle, and literal values pin the model on the key loads.
module tb_data_mem_responder;
    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        readEnable, writeEnable;
    logic [31:0] addr, writeData, readData;
    logic [2:0]  unitSize;
    logic        busy, fault;

    data_mem_responder #(.WORD_LEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .readEnable(readEnable), .writeEnable(writeEnable),
        .addr(addr), .unitSize(unitSize), .writeData(writeData),
        .readData(readData), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [7:0] mdl [MEM_BYTES];
    int checks = 0;
    int passes = 0;

    logic        expValid = 1'b0;
    logic        expBusy, expFault, expRdChk;
    logic [31:0] expRd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, got, want);
    endtask

    function automatic int sizeOf(input logic [2:0] us);
        case (us[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit isFault(input logic re, input logic we, input logic [31:0] a,
                                   input logic [2:0] us);
        if (!(re || we)) return 1'b0;
        if (us == 3'b011 || us == 3'b110 || us == 3'b111) return 1'b1;
        if (re && we) return 1'b1;
        return (longint'(a) + longint'(sizeOf(us)) - 1) >= longint'(MEM_BYTES);
    endfunction

    function automatic bit crosses(input logic [31:0] a, input logic [2:0] us);
        return (int'(a[1:0]) + sizeOf(us)) > 4;
    endfunction

    function automatic logic [31:0] mdlLoad(input logic [31:0] a, input logic [2:0] us);
        logic [31:0] v;
        int n;
        v = '0;
        n = sizeOf(us);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
        if (!us[2] && n < 4 && v[8*n-1] === 1'b1)
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (expValid) begin
            check("busy", {31'b0, busy}, {31'b0, expBusy});
            check("fault", {31'b0, fault}, {31'b0, expFault});
            if (expRdChk) check("readData", readData, expRd);
        end
    end

    task automatic doReq(input string tag, input logic re, input logic we,
                         input logic [31:0] a, input logic [2:0] us, input logic [31:0] wd,
                         input bit hasLit, input logic [31:0] lit);
        bit f, x;
        int n;
        logic [31:0] ld;
        @(posedge clk); #1;
        readEnable = re; writeEnable = we; addr = a; unitSize = us; writeData = wd;
        f  = isFault(re, we, a, us);
        n  = sizeOf(us);
        x  = !f && (re || we) && crosses(a, us);
        ld = (re && !f) ? mdlLoad(a, us) : 32'h0;
        expFault = f;
        expBusy  = x;
        expRdChk = !x;
        expRd    = ld;
        if (x) begin
            @(posedge clk); #1;
            expBusy  = 1'b0;
            expRdChk = 1'b1;
        end
        @(negedge clk);
        if (hasLit) check(tag, readData, lit);
        if (we && !f) for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        readEnable = 1'b0; writeEnable = 1'b0;
        expBusy = 1'b0; expFault = 1'b0; expRdChk = 1'b1; expRd = '0;
    endtask

    initial begin
        rst = 1'b0; readEnable = 1'b1; writeEnable = 1'b0;
        addr = 32'h10; unitSize = 3'b010; writeData = '0;
        expBusy = 1'b0; expFault = 1'b0; expRdChk = 1'b1; expRd = '0;
        expValid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; readEnable = 1'b0;

        for (int w = 0; w < 12; w++) doReq("pre", 1'b0, 1'b1, 32'(w*4), 3'b010, 32'h0, 1'b0, 32'h0);
        doReq("pre_top", 1'b0, 1'b1, 32'hFFC, 3'b010, 32'hCAFEF00D, 1'b0, 32'h0);

        doReq("sw_10",  1'b0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0);
        doReq("lw_10",  1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'hDEADBEEF);
        doReq("lb_13",  1'b1, 1'b0, 32'h13, 3'b000, 32'h0, 1'b1, 32'hFFFFFFDE);
        doReq("lbu_13", 1'b1, 1'b0, 32'h13, 3'b100, 32'h0, 1'b1, 32'h000000DE);
        doReq("lhu_12", 1'b1, 1'b0, 32'h12, 3'b101, 32'h0, 1'b1, 32'h0000DEAD);
        doReq("lh_12",  1'b1, 1'b0, 32'h12, 3'b001, 32'h0, 1'b1, 32'hFFFFDEAD);
        idleCycle();

        doReq("sb_11",  1'b0, 1'b1, 32'h11, 3'b000, 32'h00000055, 1'b0, 32'h0);
        doReq("lw_mask", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'hDEAD55EF);

        doReq("sw_0e",  1'b0, 1'b1, 32'h0E, 3'b010, 32'h11223344, 1'b0, 32'h0);
        doReq("lw_0c",  1'b1, 1'b0, 32'h0C, 3'b010, 32'h0, 1'b1, 32'h33440000);
        doReq("lw_10b", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'hDEAD1122);
        doReq("lh_0f",  1'b1, 1'b0, 32'h0F, 3'b001, 32'h0, 1'b1, 32'h00002233);
        doReq("lw_0f",  1'b1, 1'b0, 32'h0F, 3'b010, 32'h0, 1'b1, 32'hAD112233);

        doReq("lw_oob",   1'b1, 1'b0, 32'h1000, 3'b010, 32'h0, 1'b1, 32'h0);
        doReq("sh_oob",   1'b0, 1'b1, 32'hFFF, 3'b001, 32'h0000FFFF, 1'b1, 32'h0);
        doReq("bad_size", 1'b0, 1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 1'b1, 32'h0);
        doReq("both_en",  1'b1, 1'b1, 32'h10, 3'b010, 32'hFFFFFFFF, 1'b1, 32'h0);
        doReq("lw_after_fault", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'hDEAD1122);
        doReq("lw_top",   1'b1, 1'b0, 32'hFFC, 3'b010, 32'h0, 1'b1, 32'hCAFEF00D);

        // Crossing store interrupted by reset in its SPLIT cycle.
        @(posedge clk); #1;
        readEnable = 1'b0; writeEnable = 1'b1; addr = 32'h21; unitSize = 3'b010;
        writeData = 32'hAABBCCDD;
        expFault = 1'b0; expBusy = 1'b1; expRdChk = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        expBusy = 1'b0; expRdChk = 1'b1; expRd = '0;
        for (int i = 0; i < 3; i++) mdl[32'h21 + i] = writeData[8*i +: 8];
        @(posedge clk); #1;
        rst = 1'b1; writeEnable = 1'b0;
        doReq("lw_20_abort", 1'b1, 1'b0, 32'h20, 3'b010, 32'h0, 1'b1, 32'hBBCCDD00);
        doReq("lw_24_abort", 1'b1, 1'b0, 32'h24, 3'b010, 32'h0, 1'b1, 32'h00000000);
        idleCycle();

        @(posedge clk);
        expValid = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
